// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int ITERS      = HILO_WIDTH;

  localparam logic [HILO_WIDTH-1:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the datapath controller and the HI/LO muldiv unit.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_div;
  logic             unsign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, unsign, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_div, unsign, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a {upper, lower} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_nxt = acc;
    // Multiply: upper half accumulates the multiplicand, then {carry, upper, lower} shifts right.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Divide: {rem, quo} shifts left; the remainder fits in WIDTH bits after a successful subtract.
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh[WIDTH-1:0] - operand;
    if (!is_div)
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (rem_sh >= {1'b0, operand})
      acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with its own HI/LO pair and mthi/mtlo access.
// HILO_FAST_MUL_EN: when defined, multiply completes in a single CALC cycle.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  hilo_muldiv_if.slave bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               op_div;
  logic               q_neg;
  logic               r_neg;
  logic               div0;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   div0_hi;

  assign sgn   = ~bus.unsign;
  assign mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (opnd),
    .is_div  (op_div),
    .acc_nxt (acc_nxt)
  );

`ifdef HILO_FAST_MUL_EN
  assign last     = (cnt == CNT_W'(ITERS - 1)) || !op_div;
  assign prod_mag = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opnd};
`else
  assign last     = (cnt == CNT_W'(ITERS - 1));
  assign prod_mag = acc_nxt;
`endif

  assign prod_fix = q_neg ? -prod_mag : prod_mag;
  assign quo_fix  = q_neg ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
  assign rem_fix  = r_neg ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
  // The step loop is frozen on divide-by-zero, so the low half still holds |a|.
  assign div0_hi  = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      div0   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done_r <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.mthi) hi_r <= bus.wdata;
          if (bus.mtlo) lo_r <= bus.wdata;
          if (bus.start) begin
            acc    <= {{WIDTH{1'b0}}, mag_a};
            opnd   <= mag_b;
            op_div <= bus.is_div;
            q_neg  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg  <= sgn & bus.a[WIDTH-1];
            div0   <= bus.is_div && (bus.b == '0);
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          if (!div0) acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            if (!op_div) begin
              {hi_r, lo_r} <= prod_fix;
            end else if (div0) begin
              hi_r <= div0_hi;
              lo_r <= WIDTH'(DIV0_LO);
            end else begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table plus reset/busy/mthi corner sequences.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  localparam int W = 32;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int NVEC    = 12;

  typedef struct {
    string        name;
    logic         is_div;
    logic         unsign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  vec_t vecs[NVEC];
  int   n_chk  = 0;
  int   n_pass = 0;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic void model(input logic d, input logic u, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l);
    longint          sa, sb_v, q, r;
    longint unsigned p;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    if (d && b == '0) begin
      h = a;
      l = '1;
    end else if (!d) begin
      if (u) p = 64'(a) * 64'(b);
      else   p = sa * sb_v;
      {h, l} = p;
    end else if (u) begin
      l = a / b;
      h = a % b;
    end else begin
      q = sa / sb_v;
      r = sa % sb_v;
      l = q[W-1:0];
      h = r[W-1:0];
    end
  endfunction

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.is_div = 1'b0;
    bus.unsign = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    bus.wdata  = '0;
  endtask

  // Called at a falling edge; holds start for one cycle and returns at the next falling edge.
  task automatic issue(input string name, input logic d, input logic u, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input bit push);
    exp_t e;
    bus.start  = 1'b1;
    bus.is_div = d;
    bus.unsign = u;
    bus.a      = a;
    bus.b      = b;
    if (push) begin
      e.name = name;
      e.hi   = eh;
      e.lo   = el;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat <= bound) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input int lat_exp, input bit check_lat);
    int   lat;
    int   busy_n;
    exp_t e;
    wait_done(lat_exp + 10, lat, busy_n);
    e = sb.pop_front();
    check({e.name, "_done"}, W'(bus.done), W'(1));
    if (check_lat) begin
      check({e.name, "_latency"}, W'(lat), W'(lat_exp));
      check({e.name, "_busy_cycles"}, W'(busy_n), W'(lat_exp - 1));
    end
    check({e.name, "_hi"}, bus.hi, e.hi);
    check({e.name, "_lo"}, bus.lo, e.lo);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    int n_done;
    idle_inputs();

    vecs[0] = '{"multu_max",  1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg3x5", 1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"mult_minsq", 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{"div_neg7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu_7_2",   1'b1, 1'b1, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5] = '{"divu_by0",   1'b1, 1'b1, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[6] = '{"div_ovf",    1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{"div_neg_by0", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    for (int i = 8; i < NVEC; i++) begin
      vecs[i].name   = $sformatf("rand%0d", i);
      vecs[i].is_div = (i % 2) == 1;
      vecs[i].unsign = ((i / 2) % 2) == 1;
      vecs[i].a      = $urandom;
      vecs[i].b      = $urandom_range(32'hFFFFFFFF, 1);
      model(vecs[i].is_div, vecs[i].unsign, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Reset state
    #12;
    check("rst_hi", bus.hi, '0);
    check("rst_lo", bus.lo, '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // mthi / mtlo from IDLE
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h00001234;
    @(negedge clk);
    bus.mthi  = 1'b0;
    check("mthi_hi", bus.hi, 32'h00001234);
    check("mthi_lo_kept", bus.lo, '0);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h00005678;
    @(negedge clk);
    bus.mtlo  = 1'b0;
    check("mtlo_lo", bus.lo, 32'h00005678);
    check("mtlo_hi_kept", bus.hi, 32'h00001234);

    // Vector table; even entries after the first restart straight from DONE
    for (int i = 0; i < NVEC; i++) begin
      if (i % 2 == 1) begin
        @(negedge clk);
        check({vecs[i].name, "_done_pulse"}, W'(bus.done), '0);
      end
      issue(vecs[i].name, vecs[i].is_div, vecs[i].unsign, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, 1'b1);
      finish_op(vecs[i].is_div ? DIV_LAT : MUL_LAT, 1'b1);
    end

    // Start together with mthi in IDLE: write lands first, result overwrites later
    @(negedge clk);
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000CAFE;
    issue("multu_with_mthi", 1'b0, 1'b1, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
    bus.mthi  = 1'b0;
    check("mthi_first_hi", bus.hi, 32'h0000CAFE);
    finish_op(MUL_LAT - 1, 1'b0);

    // start / mthi / mtlo while busy are ignored
    @(negedge clk);
    issue("busy_ignore", 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000DEAD;
    @(negedge clk);
    idle_inputs();
    finish_op(DIV_LAT - 6, 1'b0);
    count_dones(40, n_done);
    check("no_queued_start", W'(n_done), '0);

    // Reset in the 10th busy cycle of a divide aborts with no partial result
    @(negedge clk);
    issue("aborted", 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hi", bus.hi, '0);
    check("abort_lo", bus.lo, '0);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, n_done);
    check("abort_no_done", W'(n_done), '0);
    issue("after_reset_divu", 1'b1, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    finish_op(DIV_LAT, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Multi-cycle multiply/divide unit with its own HI/LO register pair. It takes over mult/multu/div/divu from the single-cycle ALU and executes them iteratively: shift-add for multiply, restoring division for divide. It serves mfhi/mflo reads and mthi/mtlo writes. The datapath controller stalls the pipeline while busy=1.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH each.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin an operation
is_div  in  1  0 = multiply, 1 = divide
unsign  in  1  1 = unsigned (multu/divu), 0 = signed
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
mthi  in  1  write wdata into HI
mtlo  in  1  write wdata into LO
wdata  in  WIDTH  mthi/mtlo data
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle pulse: HI/LO just updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset: asynchronous on rst_n=0. hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts the operation and leaves no partial result in HI/LO.
- States: IDLE, CALC, DONE. DONE accepts start exactly as IDLE does.
- IDLE/DONE with start=1: latch |a| and |b|. Magnitudes are taken only when signed; the magnitude of 0x80000000 is 2^31 as an unsigned value. Also latch result-sign flags: product/quotient sign = a[31]^b[31]; remainder sign = a[31]. Clear the counter and go to CALC.
- CALC: one multiply or divide step per cycle, 32 cycles. busy=1 throughout. On the 32nd cycle's edge, apply two's-complement sign fixup, write {hi,lo}, and go to DONE.
- Multiply result: hi:lo is the 64-bit product.
- Divide result: lo = quotient, hi = remainder; both truncate toward zero.
- Timing: start sampled in cycle T → busy=1 in cycles T+1..T+32 → done=1 and new hi/lo visible in cycle T+33.
- Divide by zero (b=0), signed or unsigned: the step loop is bypassed and the operation still takes the full latency. Result: hi=a, lo=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural wrap; no trap is raised.
- mthi/mtlo: honoured in IDLE or DONE, taking effect at the next edge. Ignored while busy=1.
- Simultaneous start and mthi/mtlo in IDLE: the write lands first, then the operation's result overwrites both registers at completion.
- start while busy=1: ignored, no queuing.
- hi/lo are pure register outputs; no combinational path from inputs.

Optional Feature:
Macro: HILO_FAST_MUL_EN.
- Defined: multiply uses a single-cycle WIDTH×WIDTH product. busy=1 for one cycle (T+1); done and the new hi/lo appear in T+2. Divide is unchanged.
- Undefined: multiply is iterative with 32-cycle latency as specified above.
- Sign handling, reset and mthi/mtlo rules are identical in both builds.

Decomposition:
- Package hilo_pkg holds:
  - state enum (IDLE/CALC/DONE);
  - DIV0_LO constant (all ones);
  - ITERS = WIDTH constant.
- One sub-module, muldiv_step. It is combinational and computes one shift-add or restoring-subtract step from (acc, operand, is_div). The FSM, counter, sign fixup and HI/LO registers stay in hilo_muldiv.

Test Plan:
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once; busy high exactly 32 cycles.
- mult a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. mult a=b=0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- divu a=7, b=0 → hi=7, lo=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi wdata=0x1234 in IDLE → hi=0x1234 next cycle. mtlo and a second start during busy → both ignored; the original result is unchanged.
- Drop rst_n at cycle 10 of a div → hi=lo=0 and busy=0 immediately; no done pulse. A new start after rst_n rises completes normally.
